perf_counter_sampler: RTL
=========================

PERF_COUNTER_SAMPLER -- requirements
Module: perf_counter_sampler

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 13: number of consecutive counter indices swept, starting at 0.
REQ-002 SHALL have parameter WORD_WIDTH, default TIA_WORD_WIDTH (32): counter data width.
REQ-003 SHALL have parameter INDEX_WIDTH, default 4: MMIO read index width; NUM_COUNTERS <= 2**INDEX_WIDTH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum wait cycles for a read_ack.
REQ-005 clock  in  1  positive-edge clock; the block uses one clock only.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  active-high; low freezes all state.
REQ-008 sample_req  in  1  request one snapshot sweep; sampled in IDLE only.
REQ-009 busy  out  1  high while a sweep is in progress (state REQUEST).
REQ-010 done  out  1  one-cycle pulse when a sweep completes.
REQ-011 error  out  1  sticky; at least one read timed out in the last sweep.
REQ-012 snapshot_valid  out  1  snapshot holds a complete sweep.
REQ-013 read_req  out  1  MMIO host read request.
REQ-014 read_index  out  INDEX_WIDTH  MMIO counter index.
REQ-015 read_ack  in  1  MMIO device acknowledge; may be combinational in the same cycle as read_req.
REQ-016 read_data  in  WORD_WIDTH  MMIO read data, valid when read_ack=1.
REQ-017 write_req  out  1  MMIO write request; constant 0, because the block never writes.
REQ-018 snapshot_index  in  INDEX_WIDTH  local snapshot readback select.
REQ-019 snapshot_data  out  WORD_WIDTH  captured value at snapshot_index.

Function
REQ-020 SHALL implement FSM states IDLE, REQUEST and DONE, plus index register idx and wait counter wcnt.
REQ-021 IDLE: sample_req=1 and enable=1 at a clock edge -> REQUEST; idx=0, wcnt=0, error=0, snapshot_valid=0.
REQ-022 REQUEST: read_req=1 and read_index=idx combinationally; outside REQUEST, read_req=0 and read_index=0.
REQ-023 REQUEST, read_ack=1 at an edge -> snapshot[idx] <= read_data, wcnt=0; if idx=NUM_COUNTERS-1 go to DONE, else idx+1 and stay in REQUEST.
REQ-024 read_req SHALL remain high across consecutive indices; a zero-wait device completes one index per cycle.
REQ-025 REQUEST, read_ack=0: wcnt increments; when wcnt=TIMEOUT_CYCLES-1 with no ack -> snapshot[idx] <= 0, error <= 1, then advance exactly as on an ack.
REQ-026 DONE: lasts exactly one cycle with done=1; snapshot_valid <= 1; then IDLE.
REQ-027 Latency: for zero-wait acks, sample_req sampled at edge 0 -> REQUEST for cycles 1..NUM_COUNTERS, done high in cycle NUM_COUNTERS+1.
REQ-028 sample_req SHALL be ignored in REQUEST and DONE; no queuing of requests.
REQ-029 enable=0: FSM, idx, wcnt and snapshot SHALL hold; read_req forced 0; read_ack ignored; done forced 0; wcnt does not advance.
REQ-030 When enable returns high in REQUEST, read_req SHALL reassert for the same idx.
REQ-031 snapshot_data = snapshot[snapshot_index] combinationally if snapshot_index < NUM_COUNTERS, else 0.
REQ-032 snapshot_data SHALL reflect partial sweep contents while busy; consumers qualify it with snapshot_valid.
REQ-033 read_data SHALL be captured at full WORD_WIDTH with no truncation or extension.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, idx=0, wcnt=0, all snapshot entries 0, and all outputs 0 (busy, done, error, snapshot_valid, read_req, read_index, snapshot_data).
REQ-035 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the next sweep requires a fresh sample_req after reset release.

Verification
REQ-036 Zero-wait responder returning data=0x100+index, NUM_COUNTERS=13, one sample_req pulse -> 13 consecutive read_req cycles with indices 0..12, done in cycle 14, snapshot[5]=0x105, error=0.
REQ-037 Responder acks index 3 after 4 wait cycles -> read_index holds at 3 for 5 cycles, snapshot[3] captured correctly, done in cycle 18.
REQ-038 Responder never acks index 7 -> index 7 held for 15 cycles, snapshot[7]=0, error=1, sweep completes; error clears on the next sample_req.
REQ-039 enable=0 for 6 cycles during index 4 -> read_req low for those cycles, no capture, resumes at index 4, done delayed by 6 cycles.
REQ-040 reset=0 pulse at index 9 -> outputs 0 immediately, snapshot cleared, no done pulse; sample_req pulses during busy produce no second sweep.
REQ-041 snapshot_index=13 or 15 -> snapshot_data=0.

Source files
------------

// File: rtl/perf_counter_sampler_if.sv
// ----------------------------------------------------------------------------
// perf_counter_sampler_if
// MMIO read bus between the snapshot sampler (host) and the counter block
// (device).
//   read_req    host -> dev  read request, held across consecutive indices
//   read_index  host -> dev  counter index being read
//   write_req   host -> dev  write request (the sampler never writes)
//   read_ack    dev  -> host acknowledge, may be combinational on read_req
//   read_data   dev  -> host read data, valid while read_ack=1
// ----------------------------------------------------------------------------
interface perf_counter_sampler_if #(
   parameter int unsigned INDEX_WIDTH = 4,
   parameter int unsigned WORD_WIDTH  = 32
) ();

   logic                   read_req;
   logic [INDEX_WIDTH-1:0] read_index;
   logic                   write_req;
   logic                   read_ack;
   logic [WORD_WIDTH-1:0]  read_data;

   modport master (
      output read_req,
      output read_index,
      output write_req,
      input  read_ack,
      input  read_data
   );

   modport slave (
      input  read_req,
      input  read_index,
      input  write_req,
      output read_ack,
      output read_data
   );

endinterface

// File: rtl/perf_counter_sampler.sv
// ----------------------------------------------------------------------------
// perf_counter_sampler
// On a sample request, sweeps counter indices 0..NUM_COUNTERS-1 over the MMIO
// read bus and captures every value into a local snapshot array. A read that
// is not acknowledged within TIMEOUT_CYCLES cycles is recorded as 0 and flags
// a sticky error for the sweep.
//   clock           positive-edge clock
//   reset           asynchronous active-low reset
//   enable          low freezes all state and gates read_req / done
//   sample_req      starts one sweep, accepted only in IDLE
//   busy            sweep in progress
//   done            one-cycle pulse at sweep completion
//   error           at least one read of the last sweep timed out
//   snapshot_valid  snapshot holds a complete sweep
//   snapshot_index  local readback select
//   snapshot_data   captured value at snapshot_index (0 when out of range)
//   mmio            MMIO read bus, host side
// ----------------------------------------------------------------------------
module perf_counter_sampler #(
   parameter int unsigned NUM_COUNTERS   = 13,
   parameter int unsigned WORD_WIDTH     = 32,   // TIA_WORD_WIDTH
   parameter int unsigned INDEX_WIDTH    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   sample_req,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic                   snapshot_valid,
   input  logic [INDEX_WIDTH-1:0] snapshot_index,
   output logic [WORD_WIDTH-1:0]  snapshot_data,
   perf_counter_sampler_if.master mmio
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQUEST = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]             state, state_n;
   logic [INDEX_WIDTH-1:0] idx, idx_n;
   logic [CNT_W-1:0]       wcnt, wcnt_n;
   logic                   error_n;
   logic                   valid_n;
   logic                   cap_en;
   logic [WORD_WIDTH-1:0]  cap_data;
   logic                   timeout_c;
   logic                   last_c;

   logic [WORD_WIDTH-1:0]  snapshot [NUM_COUNTERS];

   assign timeout_c = (wcnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign last_c    = (idx == INDEX_WIDTH'(NUM_COUNTERS - 1));

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and datapath control; enable=0 leaves every _n at its hold value
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      wcnt_n   = wcnt;
      error_n  = error;
      valid_n  = snapshot_valid;
      cap_en   = 1'b0;
      cap_data = '0;
      if (enable) begin
         case (state)
            S_IDLE: begin
               if (sample_req) begin
                  state_n = S_REQUEST;
                  idx_n   = '0;
                  wcnt_n  = '0;
                  error_n = 1'b0;
                  valid_n = 1'b0;
               end
            end
            S_REQUEST: begin
               // An ack on the final wait cycle still wins over the timeout
               if (mmio.read_ack || timeout_c) begin
                  cap_en   = 1'b1;
                  cap_data = mmio.read_ack ? mmio.read_data : '0;
                  wcnt_n   = '0;
                  if (!mmio.read_ack) begin
                     error_n = 1'b1;
                  end
                  if (last_c) begin
                     state_n = S_DONE;
                  end else begin
                     idx_n = idx + INDEX_WIDTH'(1);
                  end
               end else begin
                  wcnt_n = wcnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               valid_n = 1'b1;
               state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // Sweep index, wait counter and status flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx            <= '0;
         wcnt           <= '0;
         error          <= 1'b0;
         snapshot_valid <= 1'b0;
      end else begin
         idx            <= idx_n;
         wcnt           <= wcnt_n;
         error          <= error_n;
         snapshot_valid <= valid_n;
      end
   end

   // Snapshot storage, written at the current sweep index
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            snapshot[i] <= '0;
         end
      end else if (cap_en) begin
         for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            if (idx == INDEX_WIDTH'(i)) begin
               snapshot[i] <= cap_data;
            end
         end
      end
   end

   // Readback mux; unmatched (out-of-range) selects fall through to 0
   always_comb begin
      snapshot_data = '0;
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
         if (snapshot_index == INDEX_WIDTH'(i)) begin
            snapshot_data = snapshot[i];
         end
      end
   end

   assign busy            = (state == S_REQUEST);
   assign done            = (state == S_DONE) && enable;
   assign mmio.read_req   = (state == S_REQUEST) && enable;
   assign mmio.read_index = (state == S_REQUEST) ? idx : '0;
   assign mmio.write_req  = 1'b0;

endmodule
